wb_retire_trace: RTL

//  Retirement trace buffer directly downstream of the WB stage of the diad pipeline.
//  - Captures one record per retiring instruction: PC, instruction word, target GP index and result.
//  - Queues records in a first-word-fall-through FIFO.
//  - Drains them over a valid/ready port to the simulation bench or a debug host.
//  - Never stalls the core: records are dropped on overflow and the drops are counted.

---
 rtl/wb_retire_trace.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_retire_trace.sv
// Retirement trace FIFO behind WB: captures retiring records, drains them over valid/ready, and counts drops on overflow.
// Optional per-record cycle stamp is enabled with `define WB_TRACE_STAMP_EN.
module wb_retire_trace #(
  parameter int PC_W    = 24,
  parameter int INSTR_W = 24,
  parameter int DATA_W  = 24,
  parameter int GP_W    = 4,
  parameter int DEPTH   = 16,
  parameter int DROP_W  = 8
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst_n,
  input  logic                     iw_wb_valid,
  input  logic [PC_W-1:0]          iw_wb_pc,
  input  logic [INSTR_W-1:0]       iw_wb_instr,
  input  logic                     iw_wb_gp_we,
  input  logic [GP_W-1:0]          iw_wb_tgt_gp,
  input  logic [DATA_W-1:0]        iw_wb_result,
  input  logic                     iw_clr,
  output logic                     ow_tr_valid,
  input  logic                     iw_tr_ready,
  output logic [PC_W-1:0]          ow_tr_pc,
  output logic [INSTR_W-1:0]       ow_tr_instr,
  output logic                     ow_tr_gp_we,
  output logic [GP_W-1:0]          ow_tr_tgt_gp,
  output logic [DATA_W-1:0]        ow_tr_result,
`ifdef WB_TRACE_STAMP_EN
  output logic [31:0]              ow_tr_stamp,
`endif
  output logic [$clog2(DEPTH):0]   ow_count,
  output logic                     ow_overflow,
  output logic [DROP_W-1:0]        ow_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef WB_TRACE_STAMP_EN
  localparam int REC_W = PC_W + INSTR_W + 1 + GP_W + DATA_W + 32;
`else
  localparam int REC_W = PC_W + INSTR_W + 1 + GP_W + DATA_W;
`endif

  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drops_q, drops_d;
  logic              valid_q, valid_d;
  logic [REC_W-1:0]  head_q, head_d;
  logic [REC_W-1:0]  wb_rec_s;
  logic              push_s, pop_s, drop_s;

`ifdef WB_TRACE_STAMP_EN
  logic [31:0] stamp_q, stamp_d;

  always_comb begin
    stamp_d = stamp_q + 32'd1;
  end

  // Free-running stamp; deliberately untouched by iw_clr.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      stamp_q <= 32'd0;
    end else begin
      stamp_q <= stamp_d;
    end
  end

  assign wb_rec_s = {iw_wb_pc, iw_wb_instr, iw_wb_gp_we, iw_wb_tgt_gp, iw_wb_result, stamp_q};
  assign {ow_tr_pc, ow_tr_instr, ow_tr_gp_we, ow_tr_tgt_gp, ow_tr_result, ow_tr_stamp} = head_q;
`else
  assign wb_rec_s = {iw_wb_pc, iw_wb_instr, iw_wb_gp_we, iw_wb_tgt_gp, iw_wb_result};
  assign {ow_tr_pc, ow_tr_instr, ow_tr_gp_we, ow_tr_tgt_gp, ow_tr_result} = head_q;
`endif

  assign ow_tr_valid = valid_q;
  assign ow_count    = count_q;
  assign ow_overflow = overflow_q;
  assign ow_drops    = drops_q;

  always_comb begin
    pop_s      = valid_q && iw_tr_ready;
    push_s     = iw_wb_valid && ((count_q < CW'(DEPTH)) || pop_s);
    drop_s     = iw_wb_valid && !push_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drops_d    = drops_q;
    if (iw_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drops_d    = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop_s) begin
        overflow_d = 1'b1;
        if (drops_q != '1) begin
          drops_d = drops_q + DROP_W'(1);
        end else begin
          drops_d = drops_q;
        end
      end else begin
        overflow_d = overflow_q;
        drops_d    = drops_q;
      end
    end
  end

  // The head register is the next head: the incoming record when it lands at the read slot, else RAM.
  always_comb begin
    valid_d = (count_d != '0);
    if (!iw_clr && push_s && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wb_rec_s;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // Record storage; contents need no reset.
  always_ff @(posedge iw_clk) begin
    if (push_s && !iw_clr) begin
      mem_q[wr_ptr_q] <= wb_rec_s;
    end
  end

  // Control state and registered head record.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drops_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drops_q    <= drops_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
    end
  end

endmodule
